// File: rtl/guest_board_rx.sv
// guest_board_rx: decodes checked SYNC/IDX/CODE/CHK packets from the UART byte stream into the
// 10x10 guest board and serves a registered read port for the display path.
module guest_board_rx #(
    parameter int         BOARD_SIZE     = 10,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       clear,
    input  logic [6:0] ship_xy_guest,
    output logic [1:0] ship_code_guest,
    output logic [6:0] ship_cells,
    output logic       pkt_ok,
    output logic       pkt_err,
    output logic       rx_busy
);
    localparam int NCELLS = BOARD_SIZE * BOARD_SIZE;
    localparam int CW     = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, GET_IDX, GET_CODE, GET_CHK, COMMIT} state_t;

    state_t                  state_q;
    logic [CW-1:0]           cnt_q;
    logic [7:0]              idx_q, code_q;
    logic [NCELLS-1:0][1:0]  board_q;
    logic [1:0]              rd_q;
    logic [6:0]              cells_q, cells_d;
    logic                    ok_q, err_q;
    logic                    pkt_valid, accept_sync, timeout;
    logic [1:0]              old_code;

    assign accept_sync = rx_valid && rx_data == SYNC_BYTE;
    assign timeout     = cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign pkt_valid   = rx_data == (SYNC_BYTE ^ idx_q ^ code_q) && idx_q < 8'(NCELLS) && code_q[7:2] == 6'd0;
    assign old_code    = board_q[idx_q[6:0]];
    // Occupancy only moves on empty<->occupied transitions, so it stays within 0..NCELLS.
    assign cells_d     = (old_code == 2'b00 && code_q[1:0] != 2'b00) ? cells_q + 7'd1 :
                         (old_code != 2'b00 && code_q[1:0] == 2'b00) ? cells_q - 7'd1 : cells_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            board_q <= '0;
            rd_q    <= 2'b00;
            cells_q <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ok_q  <= 1'b0;
            err_q <= 1'b0;
            // Sampled before any COMMIT write lands, giving read-before-write on a collision.
            rd_q  <= ship_xy_guest < 7'(NCELLS) ? board_q[ship_xy_guest] : 2'b00;
            if (clear) begin
                board_q <= '0;
                cells_q <= '0;
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE, COMMIT: begin
                        if (state_q == COMMIT) begin
                            board_q[idx_q[6:0]] <= code_q[1:0];
                            cells_q             <= cells_d;
                        end
                        cnt_q   <= '0;
                        state_q <= accept_sync ? GET_IDX : IDLE;
                    end
                    default: begin
                        cnt_q <= (rx_valid || timeout) ? '0 : cnt_q + CW'(1);
                        if (rx_valid) begin
                            if (state_q == GET_IDX) begin
                                idx_q   <= rx_data;
                                state_q <= GET_CODE;
                            end else if (state_q == GET_CODE) begin
                                code_q  <= rx_data;
                                state_q <= GET_CHK;
                            end else begin
                                ok_q    <= pkt_valid;
                                err_q   <= !pkt_valid;
                                state_q <= pkt_valid ? COMMIT : IDLE;
                            end
                        end else if (timeout) begin
                            err_q   <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign ship_code_guest = rd_q;
    assign ship_cells      = cells_q;
    assign pkt_ok          = ok_q;
    assign pkt_err         = err_q;
    assign rx_busy         = state_q == GET_IDX || state_q == GET_CODE || state_q == GET_CHK;
endmodule
